// File: rtl/fp_matrix_stream_out.sv
// fp_matrix_stream_out: snapshots a completed MxP single-precision result matrix
// and streams it row-major, one element per valid/ready beat, tagged with
// row/col indices and a last-element marker.
// Optional build macro FP_EXC_FLAG_EN adds NaN/Inf classification (out_exc)
// and a per-matrix sticky OR of that classification (exc_sticky).
module fp_matrix_stream_out #(
    parameter int M = 2,
    parameter int P = 2,
    parameter int W = 32,
    localparam int RW = (M > 1) ? $clog2(M) : 1,
    localparam int CW = (P > 1) ? $clog2(P) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [0:M*P-1][W-1:0] c_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic [RW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  out_last,
`ifdef FP_EXC_FLAG_EN
    output logic [1:0]            out_exc,
    output logic [1:0]            exc_sticky,
`endif
    output logic                  busy
);

    localparam int N  = M * P;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    buf_q [N];
    logic [W-1:0]    buf_d [N];
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic load_fire;
    logic beat_fire;
    logic last_fire;

    // Output stream view of the current buffered element; data is forced to 0
    // when nothing is being presented so idle and reset outputs read as zero.
    assign out_valid  = (state_q == STREAM);
    assign busy       = (state_q == STREAM);
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_data   = out_valid ? buf_q[idx_q] : '0;
    assign out_last   = out_valid && (row_q == RW'(M - 1)) && (col_q == CW'(P - 1));
    assign beat_fire  = out_valid && out_ready;
    assign last_fire  = beat_fire && out_last;
    assign load_ready = (state_q == IDLE) || last_fire;
    assign load_fire  = load_valid && load_ready;

`ifdef FP_EXC_FLAG_EN
    logic [1:0] exc_sticky_q, exc_sticky_d;
    logic [7:0] exp_f;
    logic       mant_nz;

    assign exp_f      = out_data[W-2 -: 8];
    assign mant_nz    = |out_data[W-10:0];
    assign out_exc    = out_valid ? {(&exp_f) && mant_nz, (&exp_f) && !mant_nz} : 2'b00;
    assign exc_sticky = exc_sticky_q;
`endif

    // Next-state: snapshot on load fire (takes priority so a load coinciding with
    // the last beat restarts at (0,0) without a bubble), otherwise advance on beats.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        for (int i = 0; i < N; i++) begin
            buf_d[i] = buf_q[i];
        end
`ifdef FP_EXC_FLAG_EN
        exc_sticky_d = exc_sticky_q;
        if (beat_fire) begin
            exc_sticky_d = exc_sticky_q | out_exc;
        end
        if (load_fire) begin
            exc_sticky_d = 2'b00;
        end
`endif
        if (load_fire) begin
            state_d = STREAM;
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
            for (int i = 0; i < N; i++) begin
                buf_d[i] = c_in[i];
            end
        end else if (last_fire) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
        end else if (beat_fire) begin
            idx_d = idx_q + 1'b1;
            if (col_q == CW'(P - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State, index and snapshot registers; async reset discards any buffered matrix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
`ifdef FP_EXC_FLAG_EN
            exc_sticky_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= buf_d[i];
            end
`ifdef FP_EXC_FLAG_EN
            exc_sticky_q <= exc_sticky_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_matrix_stream_out.sv
// Testbench for fp_matrix_stream_out (M=P=2, W=32): table-driven beat checks
// plus hand-written stall, back-to-back load, ignored load and async reset cases.
module tb_fp_matrix_stream_out;

    logic              clk;
    logic              reset_n;
    logic              load_valid;
    logic              load_ready;
    logic [0:3][31:0]  c_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [0:0]        out_row;
    logic [0:0]        out_col;
    logic              out_last;
    logic              busy;
`ifdef FP_EXC_FLAG_EN
    logic [1:0]        out_exc;
    logic [1:0]        exc_sticky;
`endif

    int checks;
    int errors;

    fp_matrix_stream_out #(.M(2), .P(2), .W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .c_in       (c_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
`ifdef FP_EXC_FLAG_EN
        .out_exc    (out_exc),
        .exc_sticky (exc_sticky),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        row;
        logic        col;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       vec_a [4];
    logic [0:3][31:0] mat_a;
    logic [0:3][31:0] mat_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a matrix for one cycle; expects the block to be ready for it.
    task automatic do_load(input logic [0:3][31:0] m);
        c_in       = m;
        load_valid = 1'b1;
        #1;
        check("load_ready_at_load", 64'(load_ready), 64'd1);
        step();
        load_valid = 1'b0;
    endtask

    // Check the presented element against matrix m at element k.
    task automatic check_beat(input string tag, input logic [0:3][31:0] m, input int k);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(m[k]));
        check({tag, "_row"},   64'(out_row),   64'(k / 2));
        check({tag, "_col"},   64'(out_col),   64'(k % 2));
        check({tag, "_last"},  64'(out_last),  64'(k == 3));
    endtask

    initial begin
        int k;
        logic pat [9];
        checks = 0;
        errors = 0;

        mat_a = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        mat_b = {32'hC0A00000, 32'h41200000, 32'h00000001, 32'hBF800000};
        vec_a[0] = '{row: 1'b0, col: 1'b0, data: 32'h3F800000, last: 1'b0};
        vec_a[1] = '{row: 1'b0, col: 1'b1, data: 32'h40000000, last: 1'b0};
        vec_a[2] = '{row: 1'b1, col: 1'b0, data: 32'h40400000, last: 1'b0};
        vec_a[3] = '{row: 1'b1, col: 1'b1, data: 32'h40800000, last: 1'b1};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        reset_n    = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        c_in       = '0;
        #12;
        // Reset values
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_out_row",    64'(out_row),    64'd0);
        check("rst_out_col",    64'(out_col),    64'd0);
        check("rst_out_last",   64'(out_last),   64'd0);
        reset_n = 1'b1;
        step();

        // Test 1: full throughput, table-driven
        out_ready = 1'b1;
        do_load(mat_a);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_busy",  64'(busy),      64'd1);
            check("t1_row",   64'(out_row),   64'(vec_a[i].row));
            check("t1_col",   64'(out_col),   64'(vec_a[i].col));
            check("t1_data",  64'(out_data),  64'(vec_a[i].data));
            check("t1_last",  64'(out_last),  64'(vec_a[i].last));
            step();
        end
        #1;
        check("t1_end_valid", 64'(out_valid), 64'd0);
        check("t1_end_busy",  64'(busy),      64'd0);
        check("t1_end_last",  64'(out_last),  64'd0);
        step();

        // Test 2: stalls with c_in overwritten after snapshot
        do_load(mat_a);
        c_in = mat_b;
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            out_ready = pat[cyc % 9];
            #1;
            check_beat("t2", mat_a, k);
            if (out_ready) k++;
            step();
        end
        check("t2_all_beats", 64'(k), 64'd4);
        #1;
        check("t2_end_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        step();

        // Test 3: back-to-back load on last beat fire
        do_load(mat_a);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                c_in       = mat_b;
                load_valid = 1'b1;
            end
            #1;
            check_beat("t3a", mat_a, i);
            if (i == 3) check("t3_load_ready_last", 64'(load_ready), 64'd1);
            step();
        end
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_beat("t3b", mat_b, i);
            if (i == 0) check("t3_load_ready_streaming", 64'(load_ready), 64'd0);
            step();
        end
        #1;
        check("t3_end_valid", 64'(out_valid), 64'd0);
        step();

        // Test 4: load pulse mid-stream is ignored
        do_load(mat_a);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                c_in       = mat_b;
                load_valid = 1'b1;
            end
            #1;
            check_beat("t4", mat_a, i);
            if (i == 1) check("t4_load_ready_mid", 64'(load_ready), 64'd0);
            step();
            load_valid = 1'b0;
        end
        #1;
        check("t4_end_busy", 64'(busy), 64'd0);
        step();

        // Test 5: async reset after the second beat
        do_load(mat_a);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid",      64'(out_valid),  64'd0);
        check("t5_rst_busy",       64'(busy),       64'd0);
        check("t5_rst_data",       64'(out_data),   64'd0);
        check("t5_rst_row",        64'(out_row),    64'd0);
        check("t5_rst_load_ready", 64'(load_ready), 64'd1);
        #1;
        reset_n = 1'b1;
        step();
        do_load(mat_b);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_beat("t5", mat_b, i);
            step();
        end
        #1;
        check("t5_end_valid", 64'(out_valid), 64'd0);
        step();

`ifdef FP_EXC_FLAG_EN
        // Test 6: NaN/Inf classification and sticky flags
        begin
            logic [0:3][31:0] mat_e;
            logic [1:0] exp_exc [4];
            mat_e   = {32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h00000000};
            exp_exc = '{2'b10, 2'b01, 2'b01, 2'b00};
            do_load(mat_e);
            check("t6_sticky_clear", 64'(exc_sticky), 64'd0);
            for (int i = 0; i < 4; i++) begin
                #1;
                check_beat("t6", mat_e, i);
                check("t6_exc", 64'(out_exc), 64'(exp_exc[i]));
                step();
            end
            #1;
            check("t6_exc_idle", 64'(out_exc),    64'd0);
            check("t6_sticky",   64'(exc_sticky), 64'd3);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
